core_inst_seq: RTL and testbench
================================

Name: core_inst_seq

Overview:
Hardware instruction sequencer for the systolic-array core. It generates the 34-bit inst word that test stimulus currently hand-sequences. For one kernel offset (kij), it runs this order of phases:
- weight fetch from xmem to L0
- weight load into the PEs
- drain
- activation fetch from xmem to L0
- execute
- OFIFO drain into pmem

It is parametrised in array size, tile length and memory map, and adds weight-reuse mode, which skips the weight phases.

Parameters:
ROW, 8, PE rows (input channels per tile)
COL, 8, PE columns (output channels per tile)
LEN_NIJ, 36, activation words per tile
LEN_KIJ, 9, kernel offsets; legal kij range 0..LEN_KIJ-1
ADDR_W, 11, xmem/pmem address width
W_BASE, 1024, xmem base address of the weight region
A_BASE, 0, xmem base address of the activation region
DRAIN_CYC, 10, idle cycles after weight load

Ports:
clk  in  1  clock
reset  in  1  synchronous active-low reset
start  in  1  one-cycle request; sampled only in IDLE
reuse_w  in  1  sampled with start; 1 = skip weight fetch, load and drain
kij  in  $clog2(LEN_KIJ)  kernel offset, sampled with start
ofifo_valid  in  1  OFIFO has a readable row
inst  out  34  core instruction word (field map below)
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse at job end

Behaviour:
- Decided interface: one clock, clk; reset is synchronous and active-low, port named reset. All outputs are registered.
- inst field map:
  - [33] acc
  - [32] CEN_pmem, [31] WEN_pmem, [30:20] A_pmem
  - [19] CEN_xmem, [18] WEN_xmem, [17:7] A_xmem
  - [6] ofifo_rd, [5] ififo_wr, [4] ififo_rd, [3] l0_rd, [2] l0_wr, [1] execute, [0] load
- Idle word is 34'h1_800C_0000: both CENs/WENs = 1, everything else 0. On reset: inst = idle word, busy = 0, done = 0, state = IDLE.
- States: IDLE -> W_RD -> W_LOAD -> DRAIN -> A_RD -> EXEC -> OF -> DONE -> IDLE. With reuse_w = 1, IDLE goes directly to A_RD.
- start is accepted on the edge where state = IDLE and start = 1. The first phase word appears in the next cycle (cycle 1). start while busy is ignored and not queued.
- W_RD (COL+1 cycles), read phase c = 0..COL-1:
  - CEN_xmem = 0, WEN_xmem = 1, A_xmem = W_BASE + kij*COL + c.
  - l0_wr = 1 in cycles c = 1..COL (SRAM has 1-cycle read latency).
- W_LOAD (ROW+COL cycles): l0_rd = 1, load = 1.
- DRAIN (DRAIN_CYC cycles): idle word.
- A_RD (LEN_NIJ+1 cycles): same read pattern as W_RD, A_xmem = A_BASE + n, with l0_wr lagging by one cycle.
- EXEC (LEN_NIJ+ROW+COL cycles): l0_rd = 1, execute = 1.
- OF phase, read side:
  - ofifo_rd = ofifo_valid, until LEN_NIJ reads are issued.
  - ofifo_valid low stalls the phase indefinitely, with no timeout.
- OF phase, write side:
  - The cycle after each read: CEN_pmem = 0, WEN_pmem = 0, A_pmem = kij*LEN_NIJ + m, where m is the read index.
  - The phase ends after the LEN_NIJ-th pmem write.
- DONE: 1 cycle, done = 1, inst = idle word, busy drops in the same cycle.
- acc, ififo_wr and ififo_rd are always 0. Accumulation is a separate block.
- Address arithmetic is ADDR_W bits and wraps modulo 2^ADDR_W. kij >= LEN_KIJ is undefined; an assertion flags it.
- Reset low mid-job: the next cycle returns to IDLE with the idle word; no partial writes continue.
- All phase counters are cleared on every state entry.

Decomposition:
- Package core_inst_pkg holds:
  - the inst bit-position localparams
  - INST_IDLE
  - the state enum
  - phase-length functions of ROW/COL/LEN_NIJ
- One natural sub-module: mem_rd_stream. It is a counter that generates the CEN/A sequence plus the 1-cycle-delayed l0_wr, and is reused by W_RD and A_RD.

Test Plan:
1. Reset held low 5 cycles with start = 1 -> inst = 34'h1_800C_0000, busy = 0, done = 0 throughout; no job starts.
2. Defaults, kij = 2, reuse_w = 0, ofifo_valid tied 1 -> cycle counts from the start edge:
   - A_xmem 1040..1047 in cycles 1-8; l0_wr in cycles 2-9.
   - load in cycles 10-25; A_xmem 0..35 in cycles 36-71.
   - execute in cycles 73-124; ofifo_rd in cycles 125-160.
   - pmem writes to 72..107 in cycles 126-161; done in cycle 162.
3. Same as 2 with reuse_w = 1 -> no load or l0 weight writes; first A_xmem = 0 in cycle 1; done in cycle 127.
4. ofifo_valid low for 5 cycles after the 10th read -> exactly 36 ofifo_rd pulses and 36 contiguous pmem addresses; done delayed by 5 cycles.
5. reset low in cycle 80 (during EXEC) -> idle word from cycle 81; busy = 0; a new start afterwards reruns the job cleanly.
6. start pulsed during cycle 40 of a job -> ignored; exactly one done pulse, and no second job.

Source files
------------

// File: rtl/core_inst_pkg.sv
// core_inst_pkg: inst word field map, idle word, sequencer states
// and phase-length helpers shared by the instruction sequencer.
package core_inst_pkg;

   localparam int INST_W     = 34;
   localparam int B_ACC      = 33;
   localparam int B_CEN_P    = 32;
   localparam int B_WEN_P    = 31;
   localparam int B_AP_HI    = 30;
   localparam int B_AP_LO    = 20;
   localparam int B_CEN_X    = 19;
   localparam int B_WEN_X    = 18;
   localparam int B_AX_HI    = 17;
   localparam int B_AX_LO    = 7;
   localparam int B_OFIFO_RD = 6;
   localparam int B_IFIFO_WR = 5;
   localparam int B_IFIFO_RD = 4;
   localparam int B_L0_RD    = 3;
   localparam int B_L0_WR    = 2;
   localparam int B_EXEC     = 1;
   localparam int B_LOAD     = 0;

   localparam logic [INST_W-1:0] INST_IDLE = 34'h1_800C_0000;

   typedef enum logic [2:0] {
      S_IDLE,
      S_W_RD,
      S_W_LOAD,
      S_DRAIN,
      S_A_RD,
      S_EXEC,
      S_OF,
      S_DONE
   } state_t;

   function automatic int w_rd_len(input int col);
      return col + 1;
   endfunction

   function automatic int w_load_len(input int row, input int col);
      return row + col;
   endfunction

   function automatic int a_rd_len(input int nij);
      return nij + 1;
   endfunction

   function automatic int exec_len(input int nij, input int row, input int col);
      return nij + row + col;
   endfunction

endpackage

// File: rtl/mem_rd_stream.sv
// mem_rd_stream: xmem read-request counter; yields the next-cycle
// CEN/address and the l0_wr that trails each read by one cycle.
module mem_rd_stream #(
   parameter int ADDR_W = 11
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              run,
   input  logic              first,
   input  logic [ADDR_W-1:0] base,
   input  logic [15:0]       len,
   output logic              cen,
   output logic [ADDR_W-1:0] addr,
   output logic              l0_wr
);

   logic [15:0] idx_q;
   logic [15:0] idx_d;
   logic        rd_on;

   assign idx_d = (first || !run) ? 16'd0 : idx_q + 16'd1;
   assign rd_on = run && (idx_d < len);
   assign cen   = !rd_on;
   assign addr  = rd_on ? base + ADDR_W'(idx_d) : '0;
   assign l0_wr = run && (idx_d != 16'd0);

   // index of the word requested in the current cycle
   always_ff @(posedge clk) begin
      if (!reset) idx_q <= '0;
      else        idx_q <= idx_d;
   end

endmodule

// File: rtl/core_inst_seq.sv
// core_inst_seq: per-kij instruction sequencer for the systolic core;
// weight fetch/load, drain, activation fetch, execute, OFIFO drain.
module core_inst_seq #(
   parameter int ROW       = 8,
   parameter int COL       = 8,
   parameter int LEN_NIJ   = 36,
   parameter int LEN_KIJ   = 9,
   parameter int ADDR_W    = 11,
   parameter int W_BASE    = 1024,
   parameter int A_BASE    = 0,
   parameter int DRAIN_CYC = 10
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       start,
   input  logic                       reuse_w,
   input  logic [$clog2(LEN_KIJ)-1:0] kij,
   input  logic                       ofifo_valid,
   output logic [33:0]                inst,
   output logic                       busy,
   output logic                       done
);

   import core_inst_pkg::*;

   localparam int          KW    = $clog2(LEN_KIJ);
   localparam logic [15:0] L_WRD = 16'(w_rd_len(COL));
   localparam logic [15:0] L_WLD = 16'(w_load_len(ROW, COL));
   localparam logic [15:0] L_DRN = 16'(DRAIN_CYC);
   localparam logic [15:0] L_ARD = 16'(a_rd_len(LEN_NIJ));
   localparam logic [15:0] L_EXE = 16'(exec_len(LEN_NIJ, ROW, COL));
   localparam logic [15:0] L_NIJ = 16'(LEN_NIJ);

   state_t            state_q;
   state_t            state_d;
   logic [15:0]       cnt_q;
   logic [15:0]       cnt_d;
   logic [15:0]       rd_n;
   logic [15:0]       wr_n;
   logic [KW-1:0]     kij_q;
   logic [KW-1:0]     kij_d;
   logic              accept;
   logic              rd_d;
   logic              wr_d;
   logic              run;
   logic              first;
   logic [ADDR_W-1:0] s_base;
   logic [ADDR_W-1:0] s_addr;
   logic [ADDR_W-1:0] pm_addr;
   logic [15:0]       s_len;
   logic              s_cen;
   logic              s_l0_wr;
   logic [33:0]       inst_d;

   assign accept  = (state_q == S_IDLE) && start;
   assign kij_d   = accept ? kij : kij_q;
   assign rd_d    = (state_d == S_OF) && ofifo_valid && (rd_n < L_NIJ);
   assign wr_d    = (state_q == S_OF) && (state_d == S_OF) && inst[B_OFIFO_RD];
   assign pm_addr = ADDR_W'(kij_q * LEN_NIJ) + ADDR_W'(wr_n);

   assign run    = (state_d == S_W_RD) || (state_d == S_A_RD);
   assign first  = state_d != state_q;
   assign s_base = (state_d == S_W_RD)
                 ? ADDR_W'(W_BASE) + ADDR_W'(kij_d * COL)
                 : ADDR_W'(A_BASE);
   assign s_len  = (state_d == S_W_RD) ? 16'(COL) : L_NIJ;

   mem_rd_stream #(
      .ADDR_W (ADDR_W)
   ) u_stream (
      .clk   (clk),
      .reset (reset),
      .run   (run),
      .first (first),
      .base  (s_base),
      .len   (s_len),
      .cen   (s_cen),
      .addr  (s_addr),
      .l0_wr (s_l0_wr)
   );

   // next phase; the phase-local counter restarts on every entry
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 16'd1;
      unique case (state_q)
         S_IDLE:   if (start) state_d = reuse_w ? S_A_RD : S_W_RD;
         S_W_RD:   if (cnt_q == L_WRD - 16'd1) state_d = S_W_LOAD;
         S_W_LOAD: if (cnt_q == L_WLD - 16'd1) state_d = S_DRAIN;
         S_DRAIN:  if (cnt_q == L_DRN - 16'd1) state_d = S_A_RD;
         S_A_RD:   if (cnt_q == L_ARD - 16'd1) state_d = S_EXEC;
         S_EXEC:   if (cnt_q == L_EXE - 16'd1) state_d = S_OF;
         S_OF:     if (wr_n == L_NIJ) state_d = S_DONE;
         S_DONE:   state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
      if (state_d != state_q) cnt_d = '0;
   end

   // word for the upcoming cycle, assembled from the next phase
   always_comb begin
      inst_d                   = INST_IDLE;
      inst_d[B_ACC]            = 1'b0;
      inst_d[B_IFIFO_WR]       = 1'b0;
      inst_d[B_IFIFO_RD]       = 1'b0;
      inst_d[B_WEN_X]          = 1'b1;
      inst_d[B_CEN_X]          = s_cen;
      inst_d[B_AX_HI:B_AX_LO]  = 11'(s_addr);
      inst_d[B_L0_WR]          = s_l0_wr;
      inst_d[B_L0_RD]          = (state_d == S_W_LOAD) || (state_d == S_EXEC);
      inst_d[B_LOAD]           = state_d == S_W_LOAD;
      inst_d[B_EXEC]           = state_d == S_EXEC;
      inst_d[B_OFIFO_RD]       = rd_d;
      inst_d[B_CEN_P]          = !wr_d;
      inst_d[B_WEN_P]          = !wr_d;
      inst_d[B_AP_HI:B_AP_LO]  = wr_d ? 11'(pm_addr) : 11'd0;
   end

   // state, counters and registered outputs
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         kij_q   <= '0;
         rd_n    <= '0;
         wr_n    <= '0;
         inst    <= INST_IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         kij_q   <= kij_d;
         rd_n    <= (state_d == S_OF) ? rd_n + 16'(rd_d) : '0;
         wr_n    <= (state_d == S_OF) ? wr_n + 16'(wr_d) : '0;
         inst    <= inst_d;
         busy    <= !((state_d == S_IDLE) || (state_d == S_DONE));
         done    <= state_d == S_DONE;
      end
   end

   // a job is never launched with an out-of-range kernel offset
   kij_range_a: assert property (
      @(posedge clk) disable iff (!reset)
      accept |-> (32'(kij) < 32'(LEN_KIJ))
   );

endmodule

// File: tb/tb_core_inst_seq.sv
// tb_core_inst_seq: directed bench for the instruction sequencer;
// per-cycle expected words are computed from the phase timeline.
module tb_core_inst_seq;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        reuse_w;
   logic [3:0]  kij;
   logic        ofifo_valid;
   logic [33:0] inst;
   logic        busy;
   logic        done;

   int n_chk = 0;
   int n_err = 0;

   localparam logic [33:0] IDLE_W = 34'h1_800C_0000;

   core_inst_seq dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .reuse_w     (reuse_w),
      .kij         (kij),
      .ofifo_valid (ofifo_valid),
      .inst        (inst),
      .busy        (busy),
      .done        (done)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [33:0] exp_word(input int k, input int kv,
                                            input bit rw);
      logic [33:0] w;
      int t0, a, e, r;
      w = IDLE_W;
      if (!rw) begin
         if (k >= 1 && k <= 8) begin
            w[19]   = 1'b0;
            w[17:7] = 11'(1024 + kv * 8 + k - 1);
         end
         if (k >= 2 && k <= 9) w[2] = 1'b1;
         if (k >= 10 && k <= 25) begin
            w[3] = 1'b1;
            w[0] = 1'b1;
         end
      end
      t0 = rw ? 1 : 36;
      a  = k - t0;
      if (a >= 0 && a <= 35) begin
         w[19]   = 1'b0;
         w[17:7] = 11'(a);
      end
      if (a >= 1 && a <= 36) w[2] = 1'b1;
      e = t0 + 37;
      if (k >= e && k < e + 52) begin
         w[3] = 1'b1;
         w[1] = 1'b1;
      end
      r = e + 52;
      if (k >= r && k < r + 36) w[6] = 1'b1;
      if (k > r && k <= r + 36) begin
         w[32]    = 1'b0;
         w[31]    = 1'b0;
         w[30:20] = 11'(kv * 36 + k - r - 1);
      end
      return w;
   endfunction

   task automatic run_job(input int kv, input bit rw, input int stall_after,
                          input int pulse_cyc);
      int  done_at, n_rd, n_wr, n_done, done_cyc, stall;
      bit  full, stalled;
      full     = (stall_after == 0);
      done_at  = (rw ? 127 : 162) + (full ? 0 : 5);
      n_rd     = 0;
      n_wr     = 0;
      n_done   = 0;
      done_cyc = 0;
      stall    = 0;
      stalled  = 0;
      kij      = 4'(kv);
      reuse_w  = rw;
      start    = 1'b1;
      step();
      start    = 1'b0;
      for (int k = 1; k <= done_at + 20; k++) begin
         if (full) begin
            chk($sformatf("inst@%0d", k), inst, exp_word(k, kv, rw));
            chk($sformatf("busy@%0d", k), busy, k < done_at);
            chk($sformatf("done@%0d", k), done, k == done_at);
         end
         if (inst[6]) n_rd++;
         if (!inst[32]) begin
            chk($sformatf("pmem_a@%0d", k), inst[30:20], kv * 36 + n_wr);
            chk($sformatf("pmem_wen@%0d", k), inst[31], 0);
            n_wr++;
         end
         if (done) begin
            n_done++;
            done_cyc = k;
         end
         if (stall > 0) begin
            stall--;
            if (stall == 0) ofifo_valid = 1'b1;
         end
         if (!full && !stalled && n_rd == stall_after) begin
            stalled     = 1;
            stall       = 5;
            ofifo_valid = 1'b0;
         end
         start = (k == pulse_cyc);
         step();
      end
      start       = 1'b0;
      ofifo_valid = 1'b1;
      chk("n_ofifo_rd", n_rd, 36);
      chk("n_pmem_wr", n_wr, 36);
      chk("n_done", n_done, 1);
      chk("done_cycle", done_cyc, done_at);
   endtask

   initial begin
      reset       = 1'b0;
      start       = 1'b1;
      reuse_w     = 1'b0;
      kij         = 4'd0;
      ofifo_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("rst_inst", inst, IDLE_W);
         chk("rst_busy", busy, 0);
         chk("rst_done", done, 0);
      end
      start = 1'b0;
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("post_rst_inst", inst, IDLE_W);
         chk("post_rst_busy", busy, 0);
      end

      run_job(2, 1'b0, 0, 0);
      run_job(2, 1'b1, 0, 0);
      run_job(2, 1'b0, 10, 0);

      kij     = 4'd2;
      reuse_w = 1'b0;
      start   = 1'b1;
      step();
      start   = 1'b0;
      for (int k = 1; k <= 80; k++) begin
         chk($sformatf("r_inst@%0d", k), inst, exp_word(k, 2, 1'b0));
         if (k == 80) reset = 1'b0;
         step();
      end
      chk("r_inst@81", inst, IDLE_W);
      chk("r_busy@81", busy, 0);
      chk("r_done@81", done, 0);
      reset = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("r_idle_inst", inst, IDLE_W);
         chk("r_idle_busy", busy, 0);
      end

      run_job(1, 1'b0, 0, 0);
      run_job(0, 1'b1, 0, 40);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_err);
      $finish;
   end

endmodule
